// File: rtl/rca_test_scheduler_if.sv
// Control/status bundle between the adder self-test scheduler and its environment.
interface rca_test_scheduler_if;
  logic       start;
  logic       abort;
  logic [3:0] sf;
  logic [3:0] cf;
  logic       test_en;
  logic [2:0] pat_idx;
  logic       busy;
  logic       done;
  logic       cfg_load;
  logic [7:0] fault_map;
  logic       map_valid;
  logic [2:0] fault_slices;
  logic       repairable;

  modport master (
    output start, abort, sf, cf,
    input  test_en, pat_idx, busy, done, cfg_load, fault_map, map_valid,
           fault_slices, repairable
  );

  modport slave (
    input  start, abort, sf, cf,
    output test_en, pat_idx, busy, done, cfg_load, fault_map, map_valid,
           fault_slices, repairable
  );
endinterface

// File: rtl/rca_test_scheduler.sv
// Self-test sequencer for the fault-tolerant ripple-carry adder: sweeps the
// pattern LUT, accumulates a sticky per-slice fault map and strobes it out.
module rca_test_scheduler #(
  parameter int NUM_PAT         = 8,
  parameter int SETTLE          = 2,
  parameter int RETEST_INTERVAL = 0
) (
  input logic                 clk,
  input logic                 clr,
  rca_test_scheduler_if.slave bus
);
  // state    | meaning
  // S_IDLE   | waiting for start or retest timer expiry
  // S_APPLY  | present pattern pat_idx to the adder
  // S_SETTLE | let adder and checkers settle (SETTLE cycles)
  // S_SAMPLE | fold sf/cf into the working map
  // S_COMMIT | merge working map into fault_map, pulse done/cfg_load
  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_COMMIT} state_t;

  localparam logic [2:0]  LAST_IDX  = 3'(NUM_PAT - 1);
  localparam logic [7:0]  SETTLE_LD = 8'(SETTLE);
  localparam logic [15:0] RETEST_LD = 16'(RETEST_INTERVAL);

  state_t      state, state_nx;
  logic [7:0]  settle_cnt;
  logic [15:0] retest_cnt;
  logic [2:0]  idx;
  logic [7:0]  work_map;
  logic [7:0]  map_q;
  logic        valid_q;
  logic [7:0]  sample_map;
  logic [2:0]  slice_cnt;
  logic        last_pat;
  logic        retest_fire;

  assign last_pat    = (idx == LAST_IDX);
  // Timer value 1 in IDLE marks the last idle cycle before the auto sweep.
  assign retest_fire = (RETEST_LD != 16'd0) && valid_q && (retest_cnt == 16'd1);

  always_comb begin
    sample_map = 8'd0;
    slice_cnt  = 3'd0;
    for (int i = 0; i < 4; i++) begin
      sample_map[2*i]   = bus.cf[i];
      sample_map[2*i+1] = bus.sf[i];
      slice_cnt = slice_cnt + {2'b00, (map_q[2*i] | map_q[2*i+1])};
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (!bus.abort && (bus.start || retest_fire)) state_nx = S_APPLY;
      S_APPLY:  state_nx = S_SETTLE;
      S_SETTLE: if (settle_cnt == 8'd1) state_nx = S_SAMPLE;
      S_SAMPLE: state_nx = last_pat ? S_COMMIT : S_APPLY;
      S_COMMIT: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (bus.abort && (state != S_IDLE)) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      settle_cnt <= 8'd0;
      retest_cnt <= 16'd0;
      idx        <= 3'd0;
      work_map   <= 8'd0;
      map_q      <= 8'd0;
      valid_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (retest_cnt != 16'd0) retest_cnt <= retest_cnt - 16'd1;
          if (state_nx == S_APPLY) begin
            work_map <= 8'd0;
            idx      <= 3'd0;
          end
        end
        S_APPLY:  settle_cnt <= SETTLE_LD;
        S_SETTLE: settle_cnt <= settle_cnt - 8'd1;
        S_SAMPLE: begin
          work_map <= work_map | sample_map;
          if (!last_pat) idx <= idx + 3'd1;
        end
        S_COMMIT: begin
          map_q      <= map_q | work_map;
          valid_q    <= 1'b1;
          retest_cnt <= RETEST_LD;
        end
        default: ;
      endcase
      if ((state != S_IDLE) && (state_nx == S_IDLE)) idx <= 3'd0;
    end
  end

  assign bus.test_en      = (state != S_IDLE);
  assign bus.busy         = (state != S_IDLE);
  assign bus.done         = (state == S_COMMIT);
  assign bus.cfg_load     = (state == S_COMMIT);
  assign bus.pat_idx      = idx;
  // Downstream latches on cfg_load, so COMMIT shows the merged map early.
  assign bus.fault_map    = (state == S_COMMIT) ? (map_q | work_map) : map_q;
  assign bus.map_valid    = valid_q;
  assign bus.fault_slices = slice_cnt;
  assign bus.repairable   = (slice_cnt <= 3'd1);
endmodule

// File: doc/rca_test_scheduler.md
# rca_test_scheduler

Self-test sequencer for the fault-tolerant ripple-carry adder. On request, or periodically, it steps the test-pattern index through every entry of the pattern LUT and holds each pattern until the adder and checkers settle. It samples the per-slice carry/sum fault flags and accumulates a sticky 8-bit fault map. When the sweep completes, it commits the map and pulses a load strobe to the reconfiguration signal generator.

## Interface
- NUM_PAT, 8, number of LUT patterns swept; legal range 1..8; index runs 0..NUM_PAT-1
- SETTLE, 2, wait cycles per pattern between apply and sample; legal range 1..255
- RETEST_INTERVAL, 0, idle cycles between automatic re-tests; 0 disables auto re-test; 16-bit
- clk  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous, active-low
- start  in  1  test request, level-sampled; acted on only in IDLE
- abort  in  1  cancel a running sweep
- sf  in  4  per-slice sum fault flags from the checkers
- cf  in  4  per-slice carry fault flags from the checkers
- test_en  out  1  selects test operands into the adder while high
- pat_idx  out  3  pattern LUT select (drives lut_i)
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse on sweep completion
- cfg_load  out  1  one-cycle strobe: latch fault_map into the reconfiguration generator
- fault_map  out  8  sticky map; bit 2i = carry fault of slice i, bit 2i+1 = sum fault of slice i
- map_valid  out  1  at least one sweep has committed since reset
- fault_slices  out  3  number of slices (0..4) with any fault bit set in fault_map
- repairable  out  1  fault_slices <= 1

## Operation
- States:
  - IDLE: test_en=0, busy=0.
  - APPLY: test_en=1, busy=1, pat_idx valid.
  - SETTLE: SETTLE cycles, settle counter counting down.
  - SAMPLE: one cycle.
  - COMMIT: one cycle.
- IDLE -> APPLY on start=1, or on retest timer expiry when RETEST_INTERVAL != 0 and map_valid=1. Entry clears the working map and sets pat_idx=0.
- APPLY -> SETTLE. The settle counter loads SETTLE and decrements each SETTLE cycle. SETTLE -> SAMPLE when the counter reaches 1.
- SAMPLE: work_map[2i] |= cf[i] and work_map[2i+1] |= sf[i]. If pat_idx == NUM_PAT-1, go to COMMIT; otherwise pat_idx+1 and go to APPLY.
- COMMIT:
  - fault_map <= fault_map | work_map. Faults are never forgotten; only clr clears the map.
  - map_valid <= 1.
  - done=1 and cfg_load=1 for this cycle only.
  - Go to IDLE and reload the retest timer with RETEST_INTERVAL.
- sf/cf are ignored outside SAMPLE.
- fault_slices and repairable are combinational from registered fault_map.
- abort=1 in any non-IDLE state: go to IDLE next cycle. Working map is discarded; fault_map, map_valid and the retest timer are unchanged. No done, no cfg_load.
- start while busy is ignored.
- start and abort both high in IDLE: abort wins, stay IDLE.
- start during the retest countdown: sweep starts immediately and the timer is reloaded at COMMIT.
- Retest timer decrements only in IDLE and saturates at 0.

## Timing
- Reset (clr=0, asynchronous):
  - state IDLE.
  - Outputs test_en, pat_idx, busy, done, cfg_load, fault_map, map_valid, fault_slices and repairable: test_en=0, pat_idx=0, busy=0, done=0, cfg_load=0, fault_map=0, map_valid=0, fault_slices=0, repairable=1.
  - Internal: retest timer=0.
- Reset mid-sweep drops test_en in the same instant without a clock edge; no partial commit.
- All other outputs are registered or Moore and change on the rising edge of clk.
- start sampled high at edge 0 gives APPLY from cycle 1.
- Pattern k uses cycles 1+k(SETTLE+2) through (k+1)(SETTLE+2). SAMPLE is the last cycle of that span.
- COMMIT, with done and cfg_load high, occurs in cycle NUM_PAT(SETTLE+2)+1. With the defaults this is cycle 33.
- fault_map shows its new value from cycle NUM_PAT(SETTLE+2)+2. cfg_load is high in the cycle before, so the downstream register captures it on the following edge from work_map-merged next state. Implement this by driving cfg_load from COMMIT and presenting fault_map|work_map as a combinational preview during COMMIT.
- busy is high from APPLY of pattern 0 through COMMIT inclusive.
- Auto re-test: the next sweep's APPLY begins RETEST_INTERVAL+1 cycles after COMMIT.

## Test plan
- Defaults, sf=cf=0, start pulse: pat_idx steps 0..7 every 4 cycles; done and cfg_load pulse together in cycle 33; fault_map=0x00, map_valid=1, repairable=1.
- cf[2]=1 only while pat_idx=5: fault_map=0x10, fault_slices=1, repairable=1. Then sf[0]=1 on a second sweep: fault_map=0x12, fault_slices=2, repairable=0.
- abort asserted in cycle 10 of a sweep: busy and test_en low in cycle 11; no done; fault_map keeps its prior value. A following start runs a full 33-cycle sweep.
- clr low mid-SETTLE with fault_map=0x12: all outputs return to reset values immediately; the next start sweeps from pat_idx=0.
- RETEST_INTERVAL=5, one start: a second sweep's APPLY begins 6 cycles after the first COMMIT. start while busy changes nothing.
- NUM_PAT=1, SETTLE=1: done in cycle 4. start and abort high together in IDLE: no sweep starts.
